// File: rtl/video_timing_pkg.sv
// Shared video definitions: 640x480@60 timing defaults, line/frame total
// derivation, default pixel pipeline latency and color width, and the
// packed raster qualifier bundle carried through the alignment pipeline.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FP        = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BP        = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FP        = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 33;
    localparam bit          DEF_HS_POL      = 1'b0;
    localparam bit          DEF_VS_POL      = 1'b0;
    // Matches the sprite block ext_color latency.
    localparam int unsigned DEF_PIXEL_DELAY = 9;
    localparam int unsigned DEF_BPP         = 8;

    function automatic int unsigned line_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL =
        line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Raw qualifiers; all-zero is the blanked/idle state the pipeline
    // resets to (hs/vs are "inside sync" flags, not pin levels).
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } raster_qual_t;

    localparam int unsigned QUAL_WIDTH = $bits(raster_qual_t);

endpackage

// File: rtl/video_timing_if.sv
// Video layer bus between the raster timing generator and its consumers.
//   count_h/count_v  raster position issued to the layer blocks
//   vblank           undelayed vertical blanking flag
//   frame_start      one-clock pulse at position (0,0)
//   pixel_color      composited layer color returned PIXEL_DELAY clocks later
//   vga_hs/vs/de     display sync and data-enable, aligned with vga_color
//   vga_color        display color, zero outside the active area
// master: timing generator side; slave: layer/display side.
interface video_timing_if
    import video_timing_pkg::*;
#(
    parameter int unsigned BPP = DEF_BPP
);
    logic [31:0]    count_h;
    logic [31:0]    count_v;
    logic           vblank;
    logic           frame_start;
    logic [BPP-1:0] pixel_color;
    logic           vga_hs;
    logic           vga_vs;
    logic           vga_de;
    logic [BPP-1:0] vga_color;

    modport master (
        output count_h, count_v, vblank, frame_start,
        output vga_hs, vga_vs, vga_de, vga_color,
        input  pixel_color
    );

    modport slave (
        input  count_h, count_v, vblank, frame_start,
        input  vga_hs, vga_vs, vga_de, vga_color,
        output pixel_color
    );

endinterface

// File: rtl/shift_register_vector.sv
// Fixed-depth delay line for a WIDTH-bit vector with synchronous clear.
//   clk    clock
//   reset  synchronous active-high, clears every stage to zero
//   d      input vector
//   q      d delayed by DEPTH clocks (DEPTH >= 1)
module shift_register_vector #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster timing generator and pixel output stage.
//   clk    pixel clock
//   reset  synchronous active-high
//   vid    video_timing_if master: issues count_h/count_v, vblank and
//          frame_start; takes pixel_color PIXEL_DELAY clocks after its
//          counts; drives vga_hs/vga_vs/vga_de/vga_color mutually aligned,
//          PIXEL_DELAY+1 clocks after the counts they belong to.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          HS_POL      = DEF_HS_POL,
    parameter bit          VS_POL      = DEF_VS_POL,
    parameter int unsigned PIXEL_DELAY = DEF_PIXEL_DELAY,
    parameter int unsigned BPP         = DEF_BPP
) (
    input  logic           clk,
    input  logic           reset,
    video_timing_if.master vid
);
    localparam logic [31:0] H_TOTAL  = 32'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam logic [31:0] V_TOTAL  = 32'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam logic [31:0] H_LAST   = H_TOTAL - 32'd1;
    localparam logic [31:0] V_LAST   = V_TOTAL - 32'd1;
    localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [31:0]              count_h;
    logic [31:0]              count_v;
    raster_qual_t             qual_raw;
    raster_qual_t             qual_dly;
    logic [QUAL_WIDTH-1:0]    qual_dly_bits;
    logic                     vga_hs_r;
    logic                     vga_vs_r;
    logic                     vga_de_r;
    logic [BPP-1:0]           vga_color_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_h <= '0;
            count_v <= '0;
        end else if (count_h == H_LAST) begin
            count_h <= '0;
            count_v <= (count_v == V_LAST) ? 32'd0 : count_v + 32'd1;
        end else begin
            count_h <= count_h + 32'd1;
        end
    end

    // vs_raw depends on count_v only, so it spans whole lines.
    always_comb begin
        qual_raw        = '0;
        qual_raw.active = (count_h < H_ACT) && (count_v < V_ACT);
        qual_raw.hs     = (count_h >= HS_START) && (count_h < HS_END);
        qual_raw.vs     = (count_v >= VS_START) && (count_v < VS_END);
    end

    // Reset clears the line to the blanked state, so a sync pulse that
    // was in flight when reset hit never reaches the pins.
    shift_register_vector #(
        .WIDTH (QUAL_WIDTH),
        .DEPTH (PIXEL_DELAY)
    ) u_qual_dly (
        .clk   (clk),
        .reset (reset),
        .d     (qual_raw),
        .q     (qual_dly_bits)
    );

    assign qual_dly = raster_qual_t'(qual_dly_bits);

    // pixel_color arrives together with qual_dly, so one register aligns
    // color with the sync/enable outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_de_r    <= 1'b0;
            vga_hs_r    <= ~HS_POL;
            vga_vs_r    <= ~VS_POL;
            vga_color_r <= '0;
        end else begin
            vga_de_r    <= qual_dly.active;
            vga_hs_r    <= qual_dly.hs ? HS_POL : ~HS_POL;
            vga_vs_r    <= qual_dly.vs ? VS_POL : ~VS_POL;
            vga_color_r <= qual_dly.active ? vid.pixel_color : '0;
        end
    end

    assign vid.count_h     = count_h;
    assign vid.count_v     = count_v;
    assign vid.vblank      = (count_v >= V_ACT);
    assign vid.frame_start = (count_h == 32'd0) && (count_v == 32'd0);
    assign vid.vga_hs      = vga_hs_r;
    assign vid.vga_vs      = vga_vs_r;
    assign vid.vga_de      = vga_de_r;
    assign vid.vga_color   = vga_color_r;

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;
    import video_timing_pkg::*;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
        logic        vb;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  col;
    } exp_t;

    // DUT A: full-width lines, short frame, 9-clock layer latency
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 4,   A_VF = 1,  A_VS = 2,  A_VB = 1;
    localparam int A_PD = 9;
    localparam bit A_HP = 1'b0, A_VP = 1'b0;
    localparam int A_HT = 800, A_VT = 8;
    // DUT B: tiny raster, 1-clock latency, positive hsync
    localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VA = 2, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_PD = 1;
    localparam bit B_HP = 1'b1, B_VP = 1'b0;
    localparam int B_HT = 7, B_VT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc_a = 8'h00;
    logic [7:0] pc_b = 8'h00;

    always #5 clk = ~clk;

    video_timing_if #(.BPP(8)) vif_a();
    video_timing_if #(.BPP(8)) vif_b();

    assign vif_a.pixel_color = pc_a;
    assign vif_b.pixel_color = pc_b;

    video_timing #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(A_HP), .VS_POL(A_VP), .PIXEL_DELAY(A_PD), .BPP(8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .vid   (vif_a)
    );

    video_timing #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(B_HP), .VS_POL(B_VP), .PIXEL_DELAY(B_PD), .BPP(8)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .vid   (vif_b)
    );

    int checks = 0;
    int errors = 0;

    exp_t       sb_a[$], sb_b[$];
    exp_t       pipe_a[$], pipe_b[$];
    logic [7:0] colq_a[$], colq_b[$];
    int         ha_m = 0, va_m = 0, hb_m = 0, vb_m = 0;
    logic       rst_prev = 1'b1;
    int         seek_reports = 0;
    bit         seek_ok = 1'b0;

    function automatic exp_t vga_exp(input int h, input int v,
                                     input int ha, input int hf, input int hsw,
                                     input int va, input int vf, input int vsw,
                                     input logic hp, input logic vp,
                                     input logic [7:0] col);
        exp_t e;
        logic act;
        e = '0;
        act = (h < ha) && (v < va);
        e.de  = act;
        e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        e.col = act ? col : 8'h00;
        return e;
    endfunction

    function automatic exp_t idle_exp(input logic hp, input logic vp);
        exp_t e;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        return e;
    endfunction

    task automatic advance(inout int h, inout int v, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    // One clock of stimulus: update the reference raster for the current
    // cycle, queue the expected outputs, drive pixel_color and reset.
    task automatic step(input logic rst_now);
        exp_t e;
        logic act;
        logic [7:0] c;
        @(negedge clk);
        if (rst_prev) begin
            ha_m = 0; va_m = 0; hb_m = 0; vb_m = 0;
            pipe_a.delete();
            pipe_b.delete();
            repeat (A_PD + 1) pipe_a.push_back(idle_exp(A_HP, A_VP));
            repeat (B_PD + 1) pipe_b.push_back(idle_exp(B_HP, B_VP));
        end else begin
            advance(ha_m, va_m, A_HT, A_VT);
            advance(hb_m, vb_m, B_HT, B_VT);
        end
        // DUT A
        e = pipe_a.pop_front();
        e.h  = 32'(ha_m);
        e.v  = 32'(va_m);
        e.vb = (va_m >= A_VA);
        e.fs = (ha_m == 0 && va_m == 0);
        sb_a.push_back(e);
        act = (ha_m < A_HA) && (va_m < A_VA);
        c = 8'(ha_m);
        colq_a.push_back(act ? c : 8'hFF);
        pc_a = colq_a.pop_front();
        pipe_a.push_back(vga_exp(ha_m, va_m, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS,
                                 A_HP, A_VP, c));
        // DUT B
        e = pipe_b.pop_front();
        e.h  = 32'(hb_m);
        e.v  = 32'(vb_m);
        e.vb = (vb_m >= B_VA);
        e.fs = (hb_m == 0 && vb_m == 0);
        sb_b.push_back(e);
        act = (hb_m < B_HA) && (vb_m < B_VA);
        c = 8'(hb_m + 16 * vb_m + 1);
        colq_b.push_back(act ? c : 8'hFF);
        pc_b = colq_b.pop_front();
        pipe_b.push_back(vga_exp(hb_m, vb_m, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS,
                                 B_HP, B_VP, c));
        reset    = rst_now;
        rst_prev = rst_now;
    endtask

    initial begin
        bit found;
        repeat (A_PD) colq_a.push_back(8'h00);
        repeat (B_PD) colq_b.push_back(8'h00);
        repeat (4) step(1'b1);
        step(1'b0);
        repeat (2 * A_HT * A_VT + 100) step(1'b0);
        // reset in the middle of vsync (line 5 of A), at column 700
        found = 1'b0;
        for (int i = 0; i < 7000 && !found; i++) begin
            step(1'b0);
            if (ha_m == 699 && va_m == 5) found = 1'b1;
        end
        seek_ok = found;
        seek_reports = seek_reports + 1;
        if (found) step(1'b1);
        repeat (2 * A_HT * A_VT + 100) step(1'b0);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic void cmp_rec(input string name, input int cyc,
                                    input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got h=%0d v=%0d vb=%b fs=%b hs=%b vs=%b de=%b col=%h expected h=%0d v=%0d vb=%b fs=%b hs=%b vs=%b de=%b col=%h",
                     name, cyc, got.h, got.v, got.vb, got.fs, got.hs, got.vs, got.de, got.col,
                     exp.h, exp.v, exp.vb, exp.fs, exp.hs, exp.vs, exp.de, exp.col);
        end
    endfunction

    function automatic void cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endfunction

    int cyc = 0;
    int seek_seen = 0;
    int fs_a = -1, vbc_a = 0, vsc_a = 0;
    int fs_b = -1, vbc_b = 0, vsc_b = 0;

    always @(negedge clk) begin
        exp_t got;
        #1;
        cyc++;
        if (sb_a.size() > 0) begin
            got = {vif_a.count_h, vif_a.count_v, vif_a.vblank, vif_a.frame_start,
                   vif_a.vga_hs, vif_a.vga_vs, vif_a.vga_de, vif_a.vga_color};
            cmp_rec("dut_a_cycle", cyc, got, sb_a.pop_front());
        end
        if (sb_b.size() > 0) begin
            got = {vif_b.count_h, vif_b.count_v, vif_b.vblank, vif_b.frame_start,
                   vif_b.vga_hs, vif_b.vga_vs, vif_b.vga_de, vif_b.vga_color};
            cmp_rec("dut_b_cycle", cyc, got, sb_b.pop_front());
        end
        if (seek_reports != seek_seen) begin
            seek_seen = seek_reports;
            cmp_int("mid_frame_seek_found", int'(seek_ok), 1);
        end
        // Whole-frame measurements between frame_start pulses; any reset
        // inside a window discards it.
        if (reset) begin
            fs_a = -1;
            fs_b = -1;
        end else begin
            if (vif_a.frame_start === 1'b1) begin
                if (fs_a >= 0) begin
                    cmp_int("a_frame_period", cyc - fs_a, A_HT * A_VT);
                    cmp_int("a_vblank_clocks", vbc_a, (A_VF + A_VS + A_VB) * A_HT);
                    cmp_int("a_vsync_clocks", vsc_a, A_VS * A_HT);
                end
                fs_a = cyc; vbc_a = 0; vsc_a = 0;
            end
            if (vif_b.frame_start === 1'b1) begin
                if (fs_b >= 0) begin
                    cmp_int("b_frame_period", cyc - fs_b, B_HT * B_VT);
                    cmp_int("b_vblank_clocks", vbc_b, (B_VF + B_VS + B_VB) * B_HT);
                    cmp_int("b_vsync_clocks", vsc_b, B_VS * B_HT);
                end
                fs_b = cyc; vbc_b = 0; vsc_b = 0;
            end
            if (vif_a.vblank === 1'b1) vbc_a++;
            if (vif_a.vga_vs === A_VP) vsc_a++;
            if (vif_b.vblank === 1'b1) vbc_b++;
            if (vif_b.vga_vs === B_VP) vsc_b++;
        end
    end

endmodule

// File: doc/video_timing.md
# video_timing

Single-clock raster timing generator and pixel output stage for the video domain. Drives the `ext_count_h`/`ext_count_v` raster position consumed by the sprite and other layer blocks, and accepts their composited `ext_color` back after a fixed pipeline latency. Emits display-ready HSYNC/VSYNC/DE/color with all four outputs mutually aligned. Provides an undelayed vblank flag and a frame-start pulse so the CPU side can time register updates.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `PIXEL_DELAY`, 9, clocks from count issue to matching `pixel_color` arrival (≥1)
- `BPP`, 8, color width

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  synchronous, active-high
- `count_h`  out  32  current raster column, 0..H_TOTAL-1
- `count_v`  out  32  current raster line, 0..V_TOTAL-1
- `vblank`  out  1  high while `count_v >= V_ACTIVE` (undelayed)
- `frame_start`  out  1  one-clock pulse when `count_h==0 && count_v==0`
- `pixel_color`  in  BPP  composited layer color, PIXEL_DELAY clocks after its counts
- `vga_hs`  out  1  horizontal sync
- `vga_vs`  out  1  vertical sync
- `vga_de`  out  1  data enable
- `vga_color`  out  BPP  output color, 0 when `vga_de` low

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Width of totals: 32-bit unsigned compares.
- `count_h` increments every clock; at H_TOTAL-1 wraps to 0 and `count_v` increments; `count_v` wraps to 0 after V_TOTAL-1 on the same clock `count_h` wraps.
- Raw (undelayed) qualifiers from counters:
  - active = `count_h < H_ACTIVE && count_v < V_ACTIVE`
  - hs_raw = `count_h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = `count_v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), full lines (changes at `count_h` wrap)
- active, hs_raw, vs_raw pass through a PIXEL_DELAY-deep pipeline, then one output register.
- Output register: `vga_de` <= active_dly; `vga_hs` <= hs_dly ? HS_POL : ~HS_POL; same for vs; `vga_color` <= active_dly ? `pixel_color` : 0.
- `vblank`, `frame_start` combinational from counter registers (glitch-free, counters are flops).

## Timing
- Reset: `count_h`=`count_v`=0; `vga_de`=0, `vga_color`=0, `vga_hs`=~HS_POL, `vga_vs`=~VS_POL; delay pipeline cleared to inactive. `frame_start` is high in the first clock after reset release (counts 0,0).
- Latency: counts at clock t → `vga_*` at t+PIXEL_DELAY+1. `pixel_color` sampled at t+PIXEL_DELAY.
- Reset mid-frame: counters and all outputs return to reset values next clock; no partial sync pulse survives — pipeline contents discarded.
- `pixel_color` ignored whenever delayed active is low (porches, sync, vblank), irrespective of value.
- No handshake; free-running; downstream layers must meet PIXEL_DELAY exactly.

## Structure
- Shared video package: timing defaults (640x480@60 constants), H_TOTAL/V_TOTAL derivation, PIXEL_DELAY default 9 (sprite ext_color latency), BPP.
- Reuse existing `shift_register_vector` (WIDTH 3, DEPTH PIXEL_DELAY) for active/hs/vs alignment; no new sub-module.

## Test plan
- Reset held 5 clocks, released → `count_h` 0,1,2…; `frame_start`=1 only at first clock; `vga_de`=0, `vga_hs`=`vga_vs`=1 (POL 0) for first 10 clocks.
- Run one line → `count_h` 799→0 and `count_v` 0→1 on same edge; `vga_hs` low for exactly 96 clocks starting 10 clocks after `count_h`==656.
- Drive `pixel_color` = low 8 bits of `count_h` delayed 9 → `vga_color` at DE pixel n equals n mod 256 for n=0..639; 0 during blanking even with `pixel_color`=8'hFF forced.
- Full frame → 420000 clocks between `frame_start` pulses; `vblank` high for 45×800 clocks; `vga_vs` low for 1600 clocks from line 490 (+10 clocks).
- Assert reset at `count_h`=700, `count_v`=491 (inside vsync) → next clock counters 0, `vga_vs`=1, `vga_de`=0; first DE 10 clocks after release.
- PIXEL_DELAY=1, small timing (H 4/1/1/1, V 2/1/1/1) → exhaustive per-clock check against reference model over 3 frames.
